dmem_arbiter_lsu: RTL and testbench

- Load/store controller and arbiter in front of the single-port, byte-enabled data memory, which has a 1-cycle synchronous read.
- Shares the memory between the CPU load/store path and a word-wide debug/loader port.
- Sequences the 1-cycle read latency with a CPU stall, checks alignment, and formats load data (sign/zero extension).
- Sits between the core datapath, the debug/UART loader and the data memory.

---
 rtl/dmem_arbiter_lsu.sv | 234 +++++++++++++++++++++++
 tb/tb_dmem_arbiter_lsu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_lsu.sv
// Load/store unit and debug arbiter in front of a single-port, byte-enabled data memory with 1-cycle read.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter_lsu #(
  parameter int unsigned DBG_STARVE_MAX = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [1:0]       cpu_size,
  input  logic             cpu_unsigned,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_stall,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_misalign,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [31:0]      dbg_wdata,
  output logic             dbg_ack,
  output logic [31:0]      dbg_rdata,
  output logic             mem_store,
  output logic [1:0]       mem_storetype,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
`ifdef DMEM_ARB_PERF_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_conflicts,
  output logic [CNT_W-1:0] perf_stalls,
`endif
  input  logic [31:0]      mem_rdata
);

  localparam int unsigned STARVE_W = (DBG_STARVE_MAX < 1) ? 1 : $clog2(DBG_STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(DBG_STARVE_MAX);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_RD   = 2'd1,
    DBG_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;
  logic [31:0]         addr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic                dbg_we_q;

  logic misalign_s;
  logic cpu_valid_s;
  logic dbg_grant_s;
  logic cpu_grant_s;
  logic stall_s;
  logic store_s;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = a[0];
      2'b10:   r = (a != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Picks the addressed byte/half out of the memory word and extends it to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Grant decision; a misaligned CPU request is treated as no request.
  always_comb begin
    misalign_s  = is_misaligned(cpu_size, cpu_addr[1:0]);
    cpu_valid_s = cpu_req && !misalign_s;
    dbg_grant_s = 1'b0;
    cpu_grant_s = 1'b0;
    if (state_q == IDLE) begin
      dbg_grant_s = dbg_req && ((DBG_STARVE_MAX == 0) || (cnt_q == STARVE_MAX) || !cpu_valid_s);
      cpu_grant_s = cpu_valid_s && !dbg_grant_s;
    end else begin
      dbg_grant_s = 1'b0;
      cpu_grant_s = 1'b0;
    end
  end

  // Starvation counter next value: cleared on debug grant, saturating otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (dbg_grant_s) begin
      cnt_d = '0;
    end else if (dbg_req && (cnt_q != STARVE_MAX)) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control FSM and capture of the load attributes needed in the data cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= 32'h0000_0000;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      dbg_we_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (dbg_grant_s) begin
            state_q  <= DBG_DONE;
            dbg_we_q <= dbg_we;
          end else if (cpu_grant_s && !cpu_we) begin
            state_q <= CPU_RD;
            addr_q  <= cpu_addr;
            size_q  <= cpu_size;
            uns_q   <= cpu_unsigned;
          end else begin
            state_q <= IDLE;
          end
        end
        CPU_RD:   state_q <= IDLE;
        DBG_DONE: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // Memory-side issue; the load address is held through the data cycle.
  always_comb begin
    mem_addr      = addr_q;
    mem_wdata     = cpu_wdata;
    mem_storetype = 2'b10;
    store_s       = 1'b0;
    if (state_q == IDLE) begin
      if (dbg_grant_s) begin
        mem_addr      = dbg_addr & 32'hFFFF_FFFC;
        mem_wdata     = dbg_wdata;
        mem_storetype = 2'b10;
        store_s       = dbg_we;
      end else if (cpu_grant_s) begin
        mem_addr      = cpu_addr;
        mem_storetype = cpu_size;
        store_s       = cpu_we;
      end else begin
        mem_addr = cpu_addr;
      end
    end else begin
      store_s = 1'b0;
    end
  end

  // CPU and debug responses; everything is quiet while reset is asserted.
  always_comb begin
    stall_s      = 1'b0;
    cpu_rdata    = 32'h0000_0000;
    dbg_rdata    = 32'h0000_0000;
    cpu_misalign = 1'b0;
    case (state_q)
      IDLE: begin
        stall_s      = cpu_valid_s && (dbg_grant_s || !cpu_we);
        cpu_misalign = cpu_req && misalign_s && reset_n;
      end
      CPU_RD: begin
        cpu_rdata = fmt_load(mem_rdata, addr_q[1:0], size_q, uns_q);
      end
      DBG_DONE: begin
        stall_s   = cpu_req;
        dbg_rdata = dbg_we_q ? 32'h0000_0000 : mem_rdata;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  assign dbg_ack   = (state_q == DBG_DONE);
  assign cpu_stall = stall_s && reset_n;
  assign mem_store = store_s && reset_n;

`ifdef DMEM_ARB_PERF_EN
  logic conflict_s;
  assign conflict_s = (state_q == IDLE) && cpu_valid_s && dbg_req;

  // Saturating performance counters; perf_clr wins over counting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_conflicts <= '0;
      perf_stalls    <= '0;
    end else if (perf_clr) begin
      perf_conflicts <= '0;
      perf_stalls    <= '0;
    end else begin
      if (conflict_s && !(&perf_conflicts)) begin
        perf_conflicts <= perf_conflicts + CNT_W'(1);
      end else begin
        perf_conflicts <= perf_conflicts;
      end
      if (cpu_stall && !(&perf_stalls)) begin
        perf_stalls <= perf_stalls + CNT_W'(1);
      end else begin
        perf_stalls <= perf_stalls;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter_lsu.sv
// Directed bench for dmem_arbiter_lsu with a byte-enabled synchronous-read memory model.
module tb_dmem_arbiter_lsu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_unsigned = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        cpu_stall, cpu_misalign;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = 32'h0, dbg_wdata = 32'h0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        mem_store;
  logic [1:0]  mem_storetype;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
`ifdef DMEM_ARB_PERF_EN
  logic        perf_clr = 1'b0;
  logic [15:0] perf_conflicts, perf_stalls;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter_lsu #(.DBG_STARVE_MAX(4), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .cpu_misalign(cpu_misalign),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_store(mem_store), .mem_storetype(mem_storetype), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_PERF_EN
    .perf_clr(perf_clr), .perf_conflicts(perf_conflicts), .perf_stalls(perf_stalls),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory model: byte lanes chosen by storetype and low address bits, read data one cycle later.
  always @(posedge clock) begin
    if (mem_store) begin
      case (mem_storetype)
        2'b00: mem[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
        2'b01: mem[mem_addr[9:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[9:2]] <= mem_wdata;
      endcase
    end
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic cpu_drive(input logic req, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_size = sz; cpu_unsigned = uns; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic test_reset();
    @(negedge clock);
    cpu_drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1111_1111);
    #1;
    checks++; if (mem_store !== 1'b0) begin failures++; $display("FAIL rst_mem_store got=%0h exp=0", mem_store); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", cpu_stall); end
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL rst_dbg_ack got=%0h exp=0", dbg_ack); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL rst_cpu_rdata got=%h exp=0", cpu_rdata); end
    checks++; if (dbg_rdata !== 32'h0) begin failures++; $display("FAIL rst_dbg_rdata got=%h exp=0", dbg_rdata); end
    checks++; if (cpu_misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%0h exp=0", cpu_misalign); end
    @(negedge clock);
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    @(negedge clock);
    cpu_drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF);
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL sw_stall got=%0h exp=0", cpu_stall); end
    checks++; if (mem_store !== 1'b1) begin failures++; $display("FAIL sw_mem_store got=%0h exp=1", mem_store); end
    checks++; if (mem_storetype !== 2'b10) begin failures++; $display("FAIL sw_storetype got=%0h exp=2", mem_storetype); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=100", mem_addr); end
    @(negedge clock);
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL lw_stall1 got=%0h exp=1", cpu_stall); end
    checks++; if (mem_store !== 1'b0) begin failures++; $display("FAIL lw_mem_store got=%0h exp=0", mem_store); end
    @(negedge clock); #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL lw_stall2 got=%0h exp=0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", cpu_rdata); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL lw_hold_addr got=%h exp=100", mem_addr); end
    @(negedge clock);
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_byte_half();
    logic [31:0] exp_v [4];
    logic [1:0]  sz_v  [4];
    logic        uns_v [4];
    logic [31:0] a_v   [4];
    exp_v = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8001, 32'h0000_8001};
    sz_v  = '{2'b00, 2'b00, 2'b01, 2'b01};
    uns_v = '{1'b0, 1'b1, 1'b0, 1'b1};
    a_v   = '{32'h103, 32'h103, 32'h102, 32'h102};
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || i == 2) begin
        @(negedge clock);
        cpu_drive(1'b1, 1'b1, sz_v[i], 1'b0, a_v[i], (i == 0) ? 32'h0000_00AA : 32'h0000_8001);
        #1;
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL sub_store_stall[%0d] got=%0h exp=0", i, cpu_stall); end
      end
      @(negedge clock);
      cpu_drive(1'b1, 1'b0, sz_v[i], uns_v[i], a_v[i], 32'h0);
      @(negedge clock); #1;
      checks++; if (cpu_rdata !== exp_v[i]) begin failures++; $display("FAIL sub_load[%0d] got=%h exp=%h", i, cpu_rdata, exp_v[i]); end
    end
    @(negedge clock);
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_misalign();
    @(negedge clock);
    cpu_drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    #1;
    checks++; if (cpu_misalign !== 1'b1) begin failures++; $display("FAIL mis_lh_pulse got=%0h exp=1", cpu_misalign); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL mis_lh_stall got=%0h exp=0", cpu_stall); end
    @(negedge clock);
    cpu_drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h102, 32'hFFFF_FFFF);
    #1;
    checks++; if (cpu_misalign !== 1'b1) begin failures++; $display("FAIL mis_sw_pulse got=%0h exp=1", cpu_misalign); end
    checks++; if (mem_store !== 1'b0) begin failures++; $display("FAIL mis_sw_store got=%0h exp=0", mem_store); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL mis_sw_stall got=%0h exp=0", cpu_stall); end
    @(negedge clock);
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (cpu_misalign !== 1'b0) begin failures++; $display("FAIL mis_clear got=%0h exp=0", cpu_misalign); end
    @(negedge clock); #1;
    checks++; if (cpu_rdata !== 32'h8001_BEEF) begin failures++; $display("FAIL mis_word_kept got=%h exp=8001beef", cpu_rdata); end
    @(negedge clock);
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_dbg_starvation();
    @(negedge clock);
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clock);
      #1;
      checks++; if (cpu_stall !== (i % 2 == 0)) begin failures++; $display("FAIL starve_stall[%0d] got=%0h", i, cpu_stall); end
      checks++; if (mem_store !== 1'b0) begin failures++; $display("FAIL starve_no_dbg[%0d] got=%0h exp=0", i, mem_store); end
      if (i % 2 == 1) begin
        checks++; if (cpu_rdata !== 32'h8001_BEEF) begin failures++; $display("FAIL starve_cpu_rdata[%0d] got=%h exp=8001beef", i, cpu_rdata); end
      end
    end
    @(negedge clock); #1;
    checks++; if (mem_store !== 1'b1) begin failures++; $display("FAIL dbg_grant_store got=%0h exp=1", mem_store); end
    checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL dbg_grant_addr got=%h exp=40", mem_addr); end
    checks++; if (mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL dbg_grant_wdata got=%h exp=12345678", mem_wdata); end
    checks++; if (mem_storetype !== 2'b10) begin failures++; $display("FAIL dbg_grant_type got=%0h exp=2", mem_storetype); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL dbg_grant_cpu_stall got=%0h exp=1", cpu_stall); end
    @(negedge clock); #1;
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL dbg_ack got=%0h exp=1", dbg_ack); end
    checks++; if (dbg_rdata !== 32'h0) begin failures++; $display("FAIL dbg_wr_rdata got=%h exp=0", dbg_rdata); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL dbg_done_cpu_stall got=%0h exp=1", cpu_stall); end
    @(negedge clock);
    dbg_req = 1'b0; dbg_we = 1'b0;
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    #1;
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_ack_pulse got=%0h exp=0", dbg_ack); end
    @(negedge clock); #1;
    checks++; if (cpu_rdata !== 32'h1234_5678) begin failures++; $display("FAIL lw_after_dbg got=%h exp=12345678", cpu_rdata); end
    @(negedge clock);
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_dbg_read();
    @(negedge clock);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h43;
    #1;
    checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL dbg_rd_addr got=%h exp=40", mem_addr); end
    checks++; if (mem_store !== 1'b0) begin failures++; $display("FAIL dbg_rd_store got=%0h exp=0", mem_store); end
    @(negedge clock); #1;
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL dbg_rd_ack got=%0h exp=1", dbg_ack); end
    checks++; if (dbg_rdata !== 32'h1234_5678) begin failures++; $display("FAIL dbg_rd_data got=%h exp=12345678", dbg_rdata); end
    @(negedge clock);
    dbg_req = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clock);
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rmo_stall_pre got=%0h exp=1", cpu_stall); end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rmo_stall got=%0h exp=0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL rmo_rdata got=%h exp=0", cpu_rdata); end
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL rmo_ack got=%0h exp=0", dbg_ack); end
    @(negedge clock);
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rmo_post_stall got=%0h exp=0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL rmo_post_rdata got=%h exp=0", cpu_rdata); end
    @(negedge clock);
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rmo_new_stall got=%0h exp=1", cpu_stall); end
    @(negedge clock); #1;
    checks++; if (cpu_rdata !== 32'h8001_BEEF) begin failures++; $display("FAIL rmo_new_rdata got=%h exp=8001beef", cpu_rdata); end
    @(negedge clock);
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

`ifdef DMEM_ARB_PERF_EN
  task automatic test_perf();
    @(negedge clock);
    perf_clr = 1'b1;
    @(negedge clock);
    perf_clr = 1'b0;
    cpu_drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h80, 32'h5555_AAAA);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'h0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    dbg_req = 1'b0; dbg_we = 1'b0;
    #1;
    checks++; if (perf_conflicts !== 16'd3) begin failures++; $display("FAIL perf_conflicts got=%0d exp=3", perf_conflicts); end
    @(negedge clock);
    perf_clr = 1'b1;
    @(negedge clock);
    perf_clr = 1'b0;
    #1;
    checks++; if (perf_conflicts !== 16'd0) begin failures++; $display("FAIL perf_clr_conf got=%0d exp=0", perf_conflicts); end
    checks++; if (perf_stalls !== 16'd0) begin failures++; $display("FAIL perf_clr_stalls got=%0d exp=0", perf_stalls); end
  endtask
`endif

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_half();
    test_misalign();
    test_dbg_starvation();
    test_dbg_read();
    test_reset_mid_op();
`ifdef DMEM_ARB_PERF_EN
    test_perf();
`endif
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
